pwm_bank_ltc2645: RTL and testbench
===================================

# pwm_bank_ltc2645

Four-channel PWM generator that consumes the NCO sample stream and drives the PWM-input pins of the LTC2645 quad DAC (DC2197 board). Each channel takes one signed duty word per sample strobe, converts it to offset binary, holds it in a shadow register and commits it only at a PWM period boundary, so no pin sees a glitched, partial period. It sits directly downstream of the NCO and clock-enable divider and is the last logic stage before the output pins.

## Interface
- `W`, 12: duty and counter width; PWM period = 2^W clk cycles.
- `N_CH`, 4: number of channels.
- `SIGNED_IN`, 1: 1 = input duty is two's complement and MSB is inverted to get offset binary; 0 = input is already unsigned.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  sample strobe; all channels present on `s_duty` this cycle.
- `s_ready`  out  1  high when the shadow register is free.
- `s_duty`  in  N_CH*W  packed duty words; channel i at [i*W +: W].
- `pwm_out`  out  N_CH  registered PWM pins.
- `frame_start`  out  1  one-cycle pulse aligned with the first pin cycle of each period.
- `overrun`  out  1  sticky; a sample arrived while `s_ready` was low.
- `clr_overrun`  in  1  synchronous clear of `overrun`.

## Operation
- Free-running counter `cnt` counts 0 .. 2^W-1 and wraps to 0. The wrap cycle is the cycle where `cnt` = 2^W-1.
- Accept occurs when `s_valid` and `s_ready` are both high. On accept, the converted words are written to the shadow register and `pending` is set to 1.
- `s_ready` = !`pending`.
- In the wrap cycle with `pending` = 1, the shadow register is copied to the active register and `pending` is cleared. `s_ready` is low in that cycle, so no accept happens.
- In the wrap cycle with `pending` = 0, the active register keeps its value. An accept in that cycle is applied at the next wrap, one full period later.
- If `s_valid` is high and `s_ready` is low, the sample is dropped and `overrun` is set. The shadow register is not overwritten.
- If `clr_overrun` and a new overrun occur in the same cycle, set wins.
- Conversion when `SIGNED_IN` = 1: `{~d[W-1], d[W-2:0]}`. Examples: -2048 -> 0, 0 -> 2048, +2047 -> 4095.
- Pin rule: `pwm_out[i]` is the registered value of (`cnt` < `active[i]`).
  - Duty 0 -> pin constantly low.
  - Duty 2^W-1 -> pin high for 2^W-1 cycles and low for 1 cycle per period.
  - Duty k -> pin high for exactly k cycles per period.
- All comparisons are unsigned, W bits wide. No saturation is needed because every input code is legal.

## Timing
- Reset values:
  - `cnt` = 0, `pending` = 0, `overrun` = 0.
  - `pwm_out` = 0, `frame_start` = 0, `s_ready` = 1.
  - Active and shadow registers = 2^(W-1), i.e. mid-scale, 50 % duty, DAC at 0 V bipolar.
- Pin latency: `pwm_out` lags `cnt` by 1 cycle. `frame_start` is the registered value of (`cnt` == 0), so it has the same alignment.
- A sample accepted at cycle t appears at the pins on the first `frame_start` after the next wrap cycle following t.
- Deassertion of `reset_n` mid-period restarts `cnt` at 0. The first `frame_start` comes 1 cycle after release.
- Maximum sustainable sample rate is one accept per period. The NCO rate (one sample per 81920 cycles) is far below this, so `overrun` must stay 0 in the system configuration.

## Structure
- Shared package `ltc2645_pkg`:
  - `PWM_W` = 12, `N_DAC_CH` = 4.
  - `MIDSCALE` constant.
  - Function `to_offset_bin(w)`.
- Sub-module `pwm_channel`, instantiated N_CH times: holds the active and shadow registers for one channel and performs the compare. It takes `cnt`, the load and commit strobes, and the converted word, and it drives the registered pin.
- The top level owns the counter, the `pending`/`s_ready` handshake, `overrun`, and `frame_start`.

## Test plan
- Reset release, no input -> every pin high for exactly 2048 of 4096 cycles; `frame_start` every 4096 cycles; `s_ready` = 1.
- One accept of signed {-2048, 0, 1023, 2047} -> channels measure 0, 2048, 3071 and 4095 high cycles respectively, starting from the first `frame_start` after the next wrap.
- Accept exactly in the wrap cycle with `pending` = 0 -> the old duty holds for one more full period, then the new duty applies.
- Two `s_valid` pulses in one period -> the first is applied, the second is dropped; `overrun` = 1 until `clr_overrun`; a simultaneous clear and new overrun leaves it at 1.
- `SIGNED_IN` = 0 with input 100 -> exactly 100 high cycles; input 0 -> pin never high.
- `reset_n` asserted mid-period with `pending` = 1 -> pins go low immediately; after release, duty is mid-scale and the pending sample is lost.

Source files
------------

// File: rtl/ltc2645_pkg.sv
// ---------------------------------------------------------------------------
// ltc2645_pkg
// Shared constants and helpers for the LTC2645 PWM output bank.
//   PWM_W         duty / counter width (period = 2^PWM_W clk cycles)
//   N_DAC_CH      number of DAC PWM inputs driven by the bank
//   MIDSCALE      offset-binary code for 50 % duty (0 V in bipolar use)
//   to_offset_bin two's complement -> offset binary (flip the MSB)
// ---------------------------------------------------------------------------
package ltc2645_pkg;

    localparam int PWM_W    = 12;
    localparam int N_DAC_CH = 4;

    localparam logic [PWM_W-1:0] MIDSCALE = {1'b1, {(PWM_W-1){1'b0}}};

    // -2^(W-1) maps to 0, 0 maps to mid-scale, +2^(W-1)-1 maps to full scale.
    function automatic logic [PWM_W-1:0] to_offset_bin(input logic [PWM_W-1:0] w);
        return {~w[PWM_W-1], w[PWM_W-2:0]};
    endfunction

endpackage

// File: rtl/pwm_bank_ltc2645_channel.sv
// ---------------------------------------------------------------------------
// pwm_channel
// One PWM lane: a shadow register loaded on sample accept, an active
// register updated only at a period boundary, and the registered compare.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   cnt           shared free-running period counter
//   load          write 'word' into the shadow register
//   commit        copy shadow into active (asserted in the wrap cycle)
//   word          duty word, already in offset binary
//   pwm_out       registered pin: high while cnt < active
// ---------------------------------------------------------------------------
module pwm_channel #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] cnt,
    input  logic         load,
    input  logic         commit,
    input  logic [W-1:0] word,
    output logic         pwm_out
);

    localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] shadow;
    logic [W-1:0] active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= MID;
        end else if (load) begin
            shadow <= word;
        end
    end

    // Active only changes on commit, so every period is generated from a
    // single, complete duty word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active <= MID;
        end else if (commit) begin
            active <= shadow;
        end
    end

    // Unsigned compare: duty 0 never goes high, full-scale leaves exactly
    // one low cycle per period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (cnt < active);
        end
    end

endmodule

// File: rtl/pwm_bank_ltc2645.sv
// ---------------------------------------------------------------------------
// pwm_bank_ltc2645
// Multi-channel PWM generator feeding the LTC2645 PWM inputs. Duty words
// arrive as one packed sample per strobe, are converted to offset binary,
// buffered in per-channel shadow registers and committed at the period wrap.
// Parameters:
//   W          duty / counter width, period = 2^W cycles
//   N_CH       number of channels
//   SIGNED_IN  1: duty is two's complement, 0: duty is already unsigned
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   s_valid       sample strobe (all channels at once)
//   s_ready       shadow register free
//   s_duty        packed duty words, channel i at [i*W +: W]
//   pwm_out       registered PWM pins
//   frame_start   one-cycle pulse on the first pin cycle of each period
//   overrun       sticky: a sample arrived while s_ready was low
//   clr_overrun   synchronous clear of overrun (a new overrun wins)
// ---------------------------------------------------------------------------
module pwm_bank_ltc2645
    import ltc2645_pkg::*;
#(
    parameter int W         = PWM_W,
    parameter int N_CH      = N_DAC_CH,
    parameter int SIGNED_IN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [N_CH*W-1:0] s_duty,
    output logic [N_CH-1:0]   pwm_out,
    output logic              frame_start,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    // Handshake: a sample is taken on any cycle where s_valid && s_ready.
    // s_ready is combinational (!pending) and s_valid is a strobe, not a
    // held request: a strobe seen while s_ready is low is discarded and
    // flagged through overrun, it is never retried.

    logic [W-1:0] cnt;
    logic         pending;
    logic         wrap;
    logic         accept;
    logic         commit;
    logic         overrun_set;

    assign wrap        = (cnt == CNT_MAX);
    assign s_ready     = !pending;
    assign accept      = s_valid && !pending;
    // pending is always high in a commit cycle, so commit and accept are
    // mutually exclusive.
    assign commit      = wrap && pending;
    assign overrun_set = s_valid && pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
        end else if (commit) begin
            pending <= 1'b0;
        end else if (accept) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    // Registered like the pins, so it lines up with the first pin cycle
    // of each period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= (cnt == '0);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [W-1:0] raw;
        logic [W-1:0] conv;

        assign raw = s_duty[i*W +: W];

        if (SIGNED_IN == 0) begin : g_unsigned
            assign conv = raw;
        end else if (W == PWM_W) begin : g_signed_pkg
            assign conv = to_offset_bin(raw);
        end else begin : g_signed_gen
            assign conv = {~raw[W-1], raw[W-2:0]};
        end

        pwm_channel #(
            .W (W)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .cnt     (cnt),
            .load    (accept),
            .commit  (commit),
            .word    (conv),
            .pwm_out (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_bank_ltc2645.sv
module tb_pwm_bank_ltc2645;

    localparam int W      = 12;
    localparam int N_CH   = 4;
    localparam int PERIOD = 4096;

    logic              clk;
    logic              reset_n;
    logic              s_valid;
    logic              s_ready;
    logic [N_CH*W-1:0] s_duty;
    logic [N_CH-1:0]   pwm_out;
    logic              frame_start;
    logic              overrun;
    logic              clr_overrun;

    // Second instance with unsigned input, same clock and reset.
    logic              s_valid_u;
    logic              s_ready_u;
    logic [N_CH*W-1:0] s_duty_u;
    logic [N_CH-1:0]   pwm_out_u;
    logic              frame_start_u;
    logic              overrun_u;

    int n_pass;
    int n_total;
    int hi_s [N_CH];
    int hi_u [N_CH];
    int n_frames;

    pwm_bank_ltc2645 #(.W(W), .N_CH(N_CH), .SIGNED_IN(1)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_duty      (s_duty),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    pwm_bank_ltc2645 #(.W(W), .N_CH(N_CH), .SIGNED_IN(0)) u_dut_u (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_valid     (s_valid_u),
        .s_ready     (s_ready_u),
        .s_duty      (s_duty_u),
        .pwm_out     (pwm_out_u),
        .frame_start (frame_start_u),
        .overrun     (overrun_u),
        .clr_overrun (1'b0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [N_CH*W-1:0] pack(input int d0, input int d1,
                                               input int d2, input int d3);
        logic [W-1:0] w0, w1, w2, w3;
        w0 = W'(d0);
        w1 = W'(d1);
        w2 = W'(d2);
        w3 = W'(d3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic wait_frame(input string tag);
        int found;
        found = 0;
        for (int k = 0; k < PERIOD + 16; k++) begin
            if (frame_start === 1'b1) begin
                found = 1;
                break;
            end
            tick();
        end
        check(tag, found, 1);
    endtask

    // Starts on a frame_start sample, counts one full period of pin samples
    // and ends on the next period's first sample.
    task automatic measure(input string tag);
        for (int c = 0; c < N_CH; c++) begin
            hi_s[c] = 0;
            hi_u[c] = 0;
        end
        n_frames = 0;
        for (int k = 0; k < PERIOD; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                hi_s[c] += int'(pwm_out[c]);
                hi_u[c] += int'(pwm_out_u[c]);
            end
            n_frames += int'(frame_start);
            tick();
        end
        check({tag, "_frames"}, n_frames, 1);
        check({tag, "_next_frame"}, int'(frame_start), 1);
    endtask

    task automatic expect_duty(input string tag,
                               input int s0, input int s1, input int s2, input int s3,
                               input int u0, input int u1, input int u2, input int u3);
        check($sformatf("%s_s0", tag), hi_s[0], s0);
        check($sformatf("%s_s1", tag), hi_s[1], s1);
        check($sformatf("%s_s2", tag), hi_s[2], s2);
        check($sformatf("%s_s3", tag), hi_s[3], s3);
        check($sformatf("%s_u0", tag), hi_u[0], u0);
        check($sformatf("%s_u1", tag), hi_u[1], u1);
        check($sformatf("%s_u2", tag), hi_u[2], u2);
        check($sformatf("%s_u3", tag), hi_u[3], u3);
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        reset_n     = 1'b0;
        s_valid     = 1'b0;
        s_duty      = '0;
        clr_overrun = 1'b0;
        s_valid_u   = 1'b0;
        s_duty_u    = '0;

        // reset state
        repeat (3) tick();
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_pwm_u", int'(pwm_out_u), 0);
        check("rst_frame", int'(frame_start), 0);
        check("rst_ready", int'(s_ready), 1);
        check("rst_overrun", int'(overrun), 0);

        // release: first frame_start one cycle later, mid-scale duty
        reset_n = 1'b1;
        tick();
        check("first_frame", int'(frame_start), 1);
        measure("mid");
        expect_duty("mid", 2048, 2048, 2048, 2048, 2048, 2048, 2048, 2048);
        check("mid_ready", int'(s_ready), 1);

        // mid-period accept, applied from the frame after the next wrap
        repeat (100) tick();
        check("acc1_ready", int'(s_ready), 1);
        s_valid   = 1'b1;
        s_duty    = pack(-2048, 0, 1023, 2047);
        s_valid_u = 1'b1;
        s_duty_u  = pack(100, 0, 4095, 1);
        tick();
        s_valid   = 1'b0;
        s_valid_u = 1'b0;
        check("acc1_pending", int'(s_ready), 0);
        check("acc1_no_overrun", int'(overrun), 0);
        wait_frame("acc1_wait");
        measure("acc1");
        expect_duty("acc1", 0, 2048, 3071, 4095, 100, 0, 4095, 1);
        check("acc1_committed", int'(s_ready), 1);

        // accept in the wrap cycle with nothing pending: one extra old period
        repeat (PERIOD - 2) tick();
        check("wrap_ready", int'(s_ready), 1);
        s_valid   = 1'b1;
        s_duty    = pack(0, -1, 100, -100);
        s_valid_u = 1'b1;
        s_duty_u  = pack(0, 100, 7, 4094);
        tick();
        s_valid   = 1'b0;
        s_valid_u = 1'b0;
        check("wrap_pending", int'(s_ready), 0);
        check("wrap_cnt0_frame", int'(frame_start), 0);
        wait_frame("wrap_wait");
        measure("wrap_old");
        expect_duty("wrap_old", 0, 2048, 3071, 4095, 100, 0, 4095, 1);
        measure("wrap_new");
        expect_duty("wrap_new", 2048, 2047, 2148, 1948, 0, 100, 7, 4094);

        // two strobes in one period: second one dropped, overrun sticky
        repeat (10) tick();
        s_valid = 1'b1;
        s_duty  = pack(-1848, 500, -1, 1500);
        tick();
        s_valid = 1'b0;
        check("ovr_pending", int'(s_ready), 0);
        repeat (10) tick();
        s_valid = 1'b1;
        s_duty  = pack(0, 0, 0, 0);
        tick();
        s_valid = 1'b0;
        check("ovr_set", int'(overrun), 1);
        wait_frame("ovr_wait");
        measure("ovr");
        expect_duty("ovr", 200, 2548, 2047, 3548, 0, 100, 7, 4094);
        check("ovr_sticky", int'(overrun), 1);
        check("ovr_u_clean", int'(overrun_u), 0);

        // clear and new overrun in the same cycle: set wins
        tick();
        s_valid = 1'b1;
        s_duty  = pack(2047, 2047, 2047, 2047);
        tick();
        check("c_pending", int'(s_ready), 0);
        s_duty      = pack(0, 0, 0, 0);
        clr_overrun = 1'b1;
        tick();
        s_valid     = 1'b0;
        check("set_wins", int'(overrun), 1);
        tick();
        clr_overrun = 1'b0;
        check("clr", int'(overrun), 0);
        check("c_still_pending", int'(s_ready), 0);

        // reset mid-period with a pending sample: pins drop, sample lost
        repeat (500) tick();
        reset_n = 1'b0;
        #1;
        check("rst2_pwm", int'(pwm_out), 0);
        check("rst2_pwm_u", int'(pwm_out_u), 0);
        check("rst2_ready", int'(s_ready), 1);
        tick();
        reset_n = 1'b1;
        tick();
        check("rst2_first_frame", int'(frame_start), 1);
        measure("rst2");
        expect_duty("rst2", 2048, 2048, 2048, 2048, 2048, 2048, 2048, 2048);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
